// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: freeze/flush sequencer for the 5-stage pipeline (data hazards, branches, SRAM waits)
// with sticky MEM timeout flag and saturating stall/flush debug counters.
module pipe_hazard_ctrl #(
    parameter int REG_W       = 4,
    parameter int WAIT_W      = 8,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src1_valid,
    input  logic             two_src,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             exe_wb_en,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_mem_r_en,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             fwd_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_freeze,
    output logic             mem_wait,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    typedef enum logic {RUN, MEM_WAIT} state_t;
    state_t state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d, flush_count_q, flush_count_d;
    logic exe_hit, mem_hit, hz, timed_out, hold, flush, stall;
    always_comb begin
        exe_hit = exe_wb_en & ((src1_valid & (src1 == exe_dest)) | (two_src & (src2 == exe_dest)));
        mem_hit = mem_wb_en & ((src1_valid & (src1 == mem_dest)) | (two_src & (src2 == mem_dest)));
        hz = fwd_en ? exe_hit & exe_mem_r_en : exe_hit | mem_hit;
        timed_out = (state_q == MEM_WAIT) & ~mem_ready & (wait_cnt_q >= WAIT_W'(MEM_TIMEOUT));
        // A waiting MEM access outranks branch and hazard; the held branch lands in the release cycle
        hold = (state_q == RUN) ? mem_req & ~mem_ready : ~mem_ready & ~timed_out;
        flush = ~hold & branch_taken;
        stall = ~hold & ~branch_taken & hz;
        state_d = hold ? MEM_WAIT : RUN;
        wait_cnt_d = hold ? wait_cnt_q + 1'b1 : '0;
        mem_timeout_d = mem_timeout_q | timed_out;
        stall_cycles_d = stall_cycles_q + CNT_W'(stall & ~&stall_cycles_q);
        flush_count_d = flush_count_q + CNT_W'(flush & ~&flush_count_q);
        pipe_freeze = ~rst & hold;
        pc_freeze = ~rst & (hold | stall);
        if_id_freeze = ~rst & (hold | stall);
        if_id_flush = ~rst & flush;
        id_ex_flush = ~rst & (flush | stall);
        mem_wait = ~rst & (state_q == MEM_WAIT);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wait_cnt_q <= '0;
            mem_timeout_q <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q <= flush_count_d;
        end
    end
    assign mem_timeout = mem_timeout_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_count = flush_count_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table-driven hazard/branch vectors plus directed MEM wait, timeout,
// branch-under-freeze, reset and counter saturation sequences.
module tb_pipe_hazard_ctrl;
    logic clk = 0, rst = 1;
    logic src1_valid, two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, fwd_en, branch_taken, mem_req, mem_ready;
    logic [3:0] src1, src2, exe_dest, mem_dest;
    logic pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, pipe_freeze, mem_wait, mem_timeout;
    logic [3:0] stall_cycles, flush_count;
    logic [4:0] outs;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    assign outs = {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, pipe_freeze};

    pipe_hazard_ctrl #(.REG_W(4), .WAIT_W(8), .MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .src1_valid(src1_valid), .two_src(two_src), .src1(src1), .src2(src2),
        .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_r_en(exe_mem_r_en), .mem_wb_en(mem_wb_en),
        .mem_dest(mem_dest), .fwd_en(fwd_en), .branch_taken(branch_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .pipe_freeze(pipe_freeze), .mem_wait(mem_wait), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    typedef struct {
        int sv, ts, s1, s2, ew, ed, er, mw, md, fe, bt, mq, mr, exp;
    } vec_t;
    vec_t v[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        {src1_valid, two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, fwd_en, branch_taken, mem_req, mem_ready} = '0;
        {src1, src2, exe_dest, mem_dest} = '0;
    endtask

    task automatic rst_dut();
        rst = 1;
        clear();
        cyc();
        rst = 0;
    endtask

    task automatic apply(input vec_t x);
        src1_valid = x.sv[0]; two_src = x.ts[0]; src1 = 4'(x.s1); src2 = 4'(x.s2);
        exe_wb_en = x.ew[0]; exe_dest = 4'(x.ed); exe_mem_r_en = x.er[0];
        mem_wb_en = x.mw[0]; mem_dest = 4'(x.md); fwd_en = x.fe[0];
        branch_taken = x.bt[0]; mem_req = x.mq[0]; mem_ready = x.mr[0];
    endtask

    task automatic load_use();
        clear();
        src1_valid = 1; src1 = 3; exe_wb_en = 1; exe_dest = 3;
    endtask

    initial begin
        int n_stall, n_flush, n;
        // {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, pipe_freeze}: stall 11010, flush 00110
        v[0]  = '{1,0,3,0,1,3,0,0,0,0,0,0,0,'b11010};
        v[1]  = '{1,0,3,0,1,3,0,0,0,1,0,0,0,0};
        v[2]  = '{1,0,3,0,1,3,1,0,0,1,0,0,0,'b11010};
        v[3]  = '{1,0,3,0,1,3,0,0,0,0,1,0,0,'b00110};
        v[4]  = '{1,1,2,5,0,0,0,1,5,0,0,0,0,'b11010};
        v[5]  = '{1,0,2,5,0,0,0,1,5,0,0,0,0,0};
        v[6]  = '{1,1,2,5,0,0,0,1,5,1,0,0,0,0};
        v[7]  = '{0,0,3,0,1,3,0,0,0,0,0,0,0,0};
        v[8]  = '{1,0,3,0,0,3,1,0,0,0,0,0,0,0};
        v[9]  = '{0,0,0,0,0,0,0,0,0,0,1,0,0,'b00110};
        v[10] = '{1,0,3,0,1,3,0,0,0,0,0,1,1,'b11010};
        v[11] = '{0,1,0,7,1,7,1,0,0,1,0,0,0,'b11010};

        // Outputs forced low while reset is held, even with a hazard present
        clear();
        load_use();
        #1 chk("rst_outs", outs, 0);
        cyc();
        rst = 0;
        clear();
        #1;
        chk("rst_stall", stall_cycles, 0);
        chk("rst_flush", flush_count, 0);
        chk("rst_timeout", mem_timeout, 0);
        chk("rst_wait", mem_wait, 0);

        n_stall = 0;
        n_flush = 0;
        for (int i = 0; i < 12; i++) begin
            apply(v[i]);
            #1;
            chk($sformatf("vec%0d_outs", i), outs, v[i].exp);
            chk($sformatf("vec%0d_wait", i), mem_wait, 0);
            if (v[i].exp == 'b11010) n_stall++;
            if (v[i].exp == 'b00110) n_flush++;
            cyc();
        end
        clear();
        #1;
        chk("vec_stall_cnt", stall_cycles, n_stall);
        chk("vec_flush_cnt", flush_count, n_flush);

        // MEM wait: 3 not-ready cycles then release
        rst_dut();
        mem_req = 1;
        #1 chk("mw1_outs", outs, 'b11001);
        chk("mw1_wait", mem_wait, 0);
        cyc();
        chk("mw2_outs", outs, 'b11001);
        chk("mw2_wait", mem_wait, 1);
        cyc();
        chk("mw3_outs", outs, 'b11001);
        chk("mw3_wait", mem_wait, 1);
        mem_ready = 1;
        #1 chk("mw_rel_outs", outs, 0);
        chk("mw_rel_wait", mem_wait, 1);
        cyc();
        clear();
        #1 chk("mw_done_wait", mem_wait, 0);

        // Branch held through a freeze: flushed once, in the release cycle
        rst_dut();
        branch_taken = 1;
        mem_req = 1;
        #1 chk("bf1_outs", outs, 'b11001);
        cyc();
        chk("bf2_outs", outs, 'b11001);
        mem_ready = 1;
        #1 chk("bf_rel_outs", outs, 'b00110);
        cyc();
        clear();
        #1 chk("bf_flush_cnt", flush_count, 1);

        // Timeout with MEM_TIMEOUT=4: RUN entry + wait_cnt 1..3 frozen, release at wait_cnt 4
        rst_dut();
        mem_req = 1;
        n = 0;
        #1;
        while (pipe_freeze && n < 20) begin
            n++;
            cyc();
        end
        chk("to_frozen", n, 4);
        chk("to_rel_wait", mem_wait, 1);
        chk("to_rel_outs", outs, 0);
        chk("to_flag_pre", mem_timeout, 0);
        cyc();
        mem_req = 0;
        #1 chk("to_flag", mem_timeout, 1);
        chk("to_run", mem_wait, 0);
        cyc();
        chk("to_sticky", mem_timeout, 1);

        // Reset in the middle of MEM_WAIT with counters and flag nonzero
        load_use();
        cyc();
        clear();
        mem_req = 1;
        cyc();
        chk("rw_wait", mem_wait, 1);
        chk("rw_stall", stall_cycles, 1);
        rst = 1;
        #1 chk("rw_rst_outs", outs, 0);
        cyc();
        rst = 0;
        clear();
        #1;
        chk("rw_outs", outs, 0);
        chk("rw_wait0", mem_wait, 0);
        chk("rw_stall0", stall_cycles, 0);
        chk("rw_to0", mem_timeout, 0);

        // Saturation of the 4-bit counters
        rst_dut();
        branch_taken = 1;
        repeat (20) cyc();
        chk("sat_flush", flush_count, 15);
        load_use();
        repeat (20) cyc();
        chk("sat_stall", stall_cycles, 15);
        chk("sat_outs", outs, 'b11010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
